cavlc_coeff_stats: RTL and testbench

Parametrised CAVLC statistics engine for one residual block, the next generation of the single-purpose zero counter. It consumes quantised coefficients in reverse zig-zag order (highest frequency first) and produces everything the CAVLC header and run encoders need for that block: TotalCoeff, TrailingOnes with their signs, TotalZeros, and a per-coefficient run_before stream. It sits between the reverse-scan buffer and the coeff_token / level / run VLC stages, and serves luma 4x4 (16), AC (15) and chroma DC (4 or 8) blocks through parameters.

---
 rtl/cavlc_coeff_stats.sv | 179 +++++++++++++++++
 tb/tb_cavlc_coeff_stats.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cavlc_coeff_stats.sv
// CAVLC statistics for one residual block: TotalCoeff, TrailingOnes and signs,
// TotalZeros and a run_before stream, from coefficients in reverse zig-zag order.
module cavlc_coeff_stats #(
    parameter int COEFF_W   = 8,
    parameter int MAX_COEFF = 16,
    parameter int CNT_W     = $clog2(MAX_COEFF + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               h264_reset,
    input  logic               blk_start,
    input  logic               coeff_valid,
    input  logic               coeff_last,
    input  logic [COEFF_W-1:0] coeff_i,
    output logic [CNT_W-1:0]   total_coeff_o,
    output logic [1:0]         trailing_ones_o,
    output logic [2:0]         t1_sign_o,
    output logic [CNT_W-1:0]   total_zeros_o,
    output logic               run_valid_o,
    output logic [CNT_W-1:0]   run_o,
    output logic               stats_valid_o,
    output logic               overflow_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] MAX_IDX = CNT_W'(MAX_COEFF);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] total_coeff_q, total_coeff_d;
    logic [1:0]       trailing_ones_q, trailing_ones_d;
    logic [2:0]       t1_sign_q, t1_sign_d;
    logic [CNT_W-1:0] total_zeros_q, total_zeros_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic             run_valid_q, run_valid_d;
    logic             stats_valid_q, stats_valid_d;
    logic             overflow_q, overflow_d;
    logic             seen_nz_q, seen_nz_d;
    logic             t1_done_q, t1_done_d;
    logic [CNT_W-1:0] idx_q, idx_d;

    logic coeff_nz;
    logic coeff_pm1;
    logic accept;

    assign coeff_nz  = |coeff_i;
    assign coeff_pm1 = (coeff_i == COEFF_W'(1)) || (coeff_i == {COEFF_W{1'b1}});
    assign accept    = coeff_valid && (blk_start || (state_q == SCAN));

    // NOTE: every _d gets a default before any branch, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        total_coeff_d   = total_coeff_q;
        trailing_ones_d = trailing_ones_q;
        t1_sign_d       = t1_sign_q;
        total_zeros_d   = total_zeros_q;
        run_cnt_d       = run_cnt_q;
        run_d           = run_q;
        run_valid_d     = 1'b0;
        stats_valid_d   = 1'b0;
        overflow_d      = overflow_q;
        seen_nz_d       = seen_nz_q;
        t1_done_d       = t1_done_q;
        idx_d           = idx_q;

        if (h264_reset) begin
            state_d         = IDLE;
            total_coeff_d   = '0;
            trailing_ones_d = '0;
            t1_sign_d       = '0;
            total_zeros_d   = '0;
            run_cnt_d       = '0;
            run_d           = '0;
            overflow_d      = 1'b0;
            seen_nz_d       = 1'b0;
            t1_done_d       = 1'b0;
            idx_d           = '0;
        end else begin
            // A coincident coefficient is applied on top of the cleared values below.
            if (blk_start) begin
                state_d         = SCAN;
                total_coeff_d   = '0;
                trailing_ones_d = '0;
                t1_sign_d       = '0;
                total_zeros_d   = '0;
                run_cnt_d       = '0;
                overflow_d      = 1'b0;
                seen_nz_d       = 1'b0;
                t1_done_d       = 1'b0;
                idx_d           = '0;
            end

            if (accept) begin
                if (idx_d < MAX_IDX) begin
                    idx_d = idx_d + CNT_ONE;
                    if (coeff_nz) begin
                        total_coeff_d = total_coeff_d + CNT_ONE;
                        if (seen_nz_d) begin
                            run_valid_d = 1'b1;
                            run_d       = run_cnt_d;
                        end
                        run_cnt_d = '0;
                        seen_nz_d = 1'b1;
                        if (!t1_done_d) begin
                            if (coeff_pm1 && (trailing_ones_d != 2'd3)) begin
                                t1_sign_d[trailing_ones_d] = coeff_i[COEFF_W-1];
                                trailing_ones_d            = trailing_ones_d + 2'd1;
                                if (trailing_ones_d == 2'd3) begin
                                    t1_done_d = 1'b1;
                                end
                            end else begin
                                t1_done_d = 1'b1;
                            end
                        end
                    end else if (seen_nz_d) begin
                        total_zeros_d = total_zeros_d + CNT_ONE;
                        run_cnt_d     = run_cnt_d + CNT_ONE;
                    end
                end else begin
                    overflow_d = 1'b1;
                end

                if (coeff_last) begin
                    state_d       = DONE;
                    stats_valid_d = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            total_coeff_q   <= '0;
            trailing_ones_q <= '0;
            t1_sign_q       <= '0;
            total_zeros_q   <= '0;
            run_cnt_q       <= '0;
            run_q           <= '0;
            run_valid_q     <= 1'b0;
            stats_valid_q   <= 1'b0;
            overflow_q      <= 1'b0;
            seen_nz_q       <= 1'b0;
            t1_done_q       <= 1'b0;
            idx_q           <= '0;
        end else begin
            state_q         <= state_d;
            total_coeff_q   <= total_coeff_d;
            trailing_ones_q <= trailing_ones_d;
            t1_sign_q       <= t1_sign_d;
            total_zeros_q   <= total_zeros_d;
            run_cnt_q       <= run_cnt_d;
            run_q           <= run_d;
            run_valid_q     <= run_valid_d;
            stats_valid_q   <= stats_valid_d;
            overflow_q      <= overflow_d;
            seen_nz_q       <= seen_nz_d;
            t1_done_q       <= t1_done_d;
            idx_q           <= idx_d;
        end
    end

    assign total_coeff_o   = total_coeff_q;
    assign trailing_ones_o = trailing_ones_q;
    assign t1_sign_o       = t1_sign_q;
    assign total_zeros_o   = total_zeros_q;
    assign run_valid_o     = run_valid_q;
    assign run_o           = run_q;
    assign stats_valid_o   = stats_valid_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_cavlc_coeff_stats.sv
// Bench for cavlc_coeff_stats: 16- and 4-coefficient instances share one stimulus
// stream and are checked every cycle against a block-level model plus literal results.
module tb_cavlc_coeff_stats;

    logic       clk;
    logic       rst;
    logic       h264_reset;
    logic       blk_start;
    logic       coeff_valid;
    logic       coeff_last;
    logic [7:0] coeff_i;

    logic [4:0] tc16, tz16, run16;
    logic [1:0] to16;
    logic [2:0] sg16;
    logic       rv16, sv16, ovf16;
    logic [2:0] tc4, tz4, run4;
    logic [1:0] to4;
    logic [2:0] sg4;
    logic       rv4, sv4, ovf4;

    cavlc_coeff_stats #(.COEFF_W(8), .MAX_COEFF(16)) dut16 (
        .clk(clk), .rst(rst), .h264_reset(h264_reset), .blk_start(blk_start),
        .coeff_valid(coeff_valid), .coeff_last(coeff_last), .coeff_i(coeff_i),
        .total_coeff_o(tc16), .trailing_ones_o(to16), .t1_sign_o(sg16),
        .total_zeros_o(tz16), .run_valid_o(rv16), .run_o(run16),
        .stats_valid_o(sv16), .overflow_o(ovf16)
    );

    cavlc_coeff_stats #(.COEFF_W(8), .MAX_COEFF(4)) dut4 (
        .clk(clk), .rst(rst), .h264_reset(h264_reset), .blk_start(blk_start),
        .coeff_valid(coeff_valid), .coeff_last(coeff_last), .coeff_i(coeff_i),
        .total_coeff_o(tc4), .trailing_ones_o(to4), .t1_sign_o(sg4),
        .total_zeros_o(tz4), .run_valid_o(rv4), .run_o(run4),
        .stats_valid_o(sv4), .overflow_o(ovf4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model: the accepted coefficients of the current block are stored, and the
    // statistics are recomputed from that list whenever they are compared.
    int m_state[2];
    int m_n[2];
    int m_idx[2];
    bit m_ovf[2];
    int m_blk[2][16];
    bit m_rv[2];
    int m_run[2];
    bit m_sv[2];

    function automatic int maxc(input int k);
        return (k == 0) ? 16 : 4;
    endfunction

    task automatic model_clear(input int k);
        m_state[k] = 0;
        m_n[k]     = 0;
        m_idx[k]   = 0;
        m_ovf[k]   = 1'b0;
        m_rv[k]    = 1'b0;
        m_run[k]   = 0;
        m_sv[k]    = 1'b0;
    endtask

    task automatic model_step(input int k);
        int c;
        int j;
        bit acc;
        if (h264_reset) begin
            model_clear(k);
            return;
        end
        m_rv[k] = 1'b0;
        m_sv[k] = 1'b0;
        acc = coeff_valid && (blk_start || m_state[k] == 1);
        if (blk_start) begin
            m_n[k]     = 0;
            m_idx[k]   = 0;
            m_ovf[k]   = 1'b0;
            m_state[k] = 1;
        end
        if (acc) begin
            if (m_idx[k] < maxc(k)) begin
                c = int'($signed(coeff_i));
                if (c != 0) begin
                    j = m_n[k] - 1;
                    while (j >= 0 && m_blk[k][j] == 0) j--;
                    if (j >= 0) begin
                        m_rv[k]  = 1'b1;
                        m_run[k] = m_n[k] - 1 - j;
                    end
                end
                m_blk[k][m_n[k]] = c;
                m_n[k]++;
            end else begin
                m_ovf[k] = 1'b1;
            end
            m_idx[k]++;
            if (coeff_last) begin
                m_state[k] = 2;
                m_sv[k]    = 1'b1;
            end
        end
    endtask

    function automatic void calc(input int k, output int tc, output int to,
                                 output int sg, output int tz);
        int first;
        bit done;
        tc = 0; to = 0; sg = 0; tz = 0; first = -1; done = 1'b0;
        for (int i = 0; i < m_n[k]; i++) begin
            if (m_blk[k][i] != 0) begin
                tc++;
                if (first < 0) first = i;
                if (!done) begin
                    if ((m_blk[k][i] == 1 || m_blk[k][i] == -1) && to < 3) begin
                        if (m_blk[k][i] < 0) sg = sg | (1 << to);
                        to++;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
        end
        if (first >= 0) tz = (m_n[k] - first) - tc;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) model_clear(k);
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    task automatic cmp_inst(input int k, input logic [31:0] tc, input logic [31:0] to,
                            input logic [31:0] sg, input logic [31:0] tz,
                            input logic [31:0] rv, input logic [31:0] run,
                            input logic [31:0] sv, input logic [31:0] ovf);
        int e_tc, e_to, e_sg, e_tz;
        string p;
        p = (k == 0) ? "m16" : "m4";
        calc(k, e_tc, e_to, e_sg, e_tz);
        check({p, ".total_coeff"}, tc, e_tc);
        check({p, ".trailing_ones"}, to, e_to);
        check({p, ".t1_sign"}, sg, e_sg);
        check({p, ".total_zeros"}, tz, e_tz);
        check({p, ".run_valid"}, rv, 32'(m_rv[k]));
        check({p, ".run"}, run, m_run[k]);
        check({p, ".stats_valid"}, sv, 32'(m_sv[k]));
        check({p, ".overflow"}, ovf, 32'(m_ovf[k]));
    endtask

    always @(negedge clk) begin
        cmp_inst(0, 32'(tc16), 32'(to16), 32'(sg16), 32'(tz16), 32'(rv16), 32'(run16),
                 32'(sv16), 32'(ovf16));
        cmp_inst(1, 32'(tc4), 32'(to4), 32'(sg4), 32'(tz4), 32'(rv4), 32'(run4),
                 32'(sv4), 32'(ovf4));
    end

    // Observed pulses, used by the literal checks.
    int cyc = 0;
    int runs16[$];
    int runs4[$];
    int sv_cycles[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rv16) runs16.push_back(int'(run16));
        if (rv4) runs4.push_back(int'(run4));
        if (sv16) sv_cycles.push_back(cyc);
    end

    task automatic send(input bit bs, input int c, input bit last);
        blk_start   = bs;
        coeff_valid = 1'b1;
        coeff_i     = 8'(c);
        coeff_last  = last;
        @(posedge clk);
        #1;
        blk_start   = 1'b0;
        coeff_valid = 1'b0;
        coeff_i     = '0;
        coeff_last  = 1'b0;
    endtask

    task automatic send_block(input int q[$]);
        for (int i = 0; i < q.size(); i++) send(i == 0, q[i], i == q.size() - 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        runs16.delete();
        runs4.delete();
        sv_cycles.delete();
    endtask

    initial begin
        int q[$];
        rst = 1'b0; h264_reset = 1'b0; blk_start = 1'b0;
        coeff_valid = 1'b0; coeff_last = 1'b0; coeff_i = '0;
        idle(2);
        rst = 1'b1;
        idle(1);
        check("reset.total_coeff", 32'(tc16), 0);
        check("reset.t1_sign", 32'(sg16), 0);
        check("reset.stats_valid", 32'(sv16), 0);

        // Mixed block: runs 1,2,1 and two trailing ones.
        clear_obs();
        q = '{0, 0, 1, 0, -1, 0, 0, 3, 0, 2, 0, 0, 0, 0, 0, 0};
        send_block(q);
        check("b1.stats_valid", 32'(sv16), 1);
        check("b1.total_coeff", 32'(tc16), 4);
        check("b1.trailing_ones", 32'(to16), 2);
        check("b1.t1_sign", 32'(sg16), 3'b010);
        check("b1.total_zeros", 32'(tz16), 10);
        idle(3);
        check("b1.run_count", runs16.size(), 3);
        if (runs16.size() == 3) begin
            check("b1.run0", runs16[0], 1);
            check("b1.run1", runs16[1], 2);
            check("b1.run2", runs16[2], 1);
        end
        check("b1.sv_pulses", sv_cycles.size(), 1);
        check("b1.held_total_coeff", 32'(tc16), 4);

        // All-zero block.
        clear_obs();
        q = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_block(q);
        check("b2.stats_valid", 32'(sv16), 1);
        check("b2.total_coeff", 32'(tc16), 0);
        check("b2.total_zeros", 32'(tz16), 0);
        idle(2);
        check("b2.run_count", runs16.size(), 0);
        check("b2.sv_pulses", sv_cycles.size(), 1);

        // MAX_COEFF=4 block; the 16-wide instance sees the same short block.
        clear_obs();
        q = '{0, 5, 0, -1};
        send_block(q);
        check("b4.total_coeff", 32'(tc4), 2);
        check("b4.trailing_ones", 32'(to4), 0);
        check("b4.total_zeros", 32'(tz4), 1);
        check("b4.overflow", 32'(ovf4), 0);
        idle(1);
        check("b4.run_count", runs4.size(), 1);
        if (runs4.size() == 1) check("b4.run0", runs4[0], 1);

        // Seventeen coefficients: the 17th is excluded and overflow is flagged.
        clear_obs();
        q = '{2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5};
        send_block(q);
        check("ovf.stats_valid", 32'(sv16), 1);
        check("ovf.overflow16", 32'(ovf16), 1);
        check("ovf.total_coeff16", 32'(tc16), 1);
        check("ovf.total_zeros16", 32'(tz16), 15);
        check("ovf.overflow4", 32'(ovf4), 1);
        check("ovf.total_zeros4", 32'(tz4), 3);
        idle(2);

        // Back-to-back blocks, second opened in the cycle after the first's last.
        clear_obs();
        q = '{1, 0, 2};
        send_block(q);
        q = '{0, -1, 0, 1};
        send_block(q);
        check("bb.total_coeff", 32'(tc16), 2);
        check("bb.trailing_ones", 32'(to16), 2);
        check("bb.t1_sign", 32'(sg16), 3'b001);
        check("bb.total_zeros", 32'(tz16), 1);
        idle(2);
        check("bb.sv_pulses", sv_cycles.size(), 2);
        if (sv_cycles.size() == 2) check("bb.sv_spacing", sv_cycles[1] - sv_cycles[0], 4);

        // blk_start inside SCAN restarts the block with its own coefficient.
        clear_obs();
        send(1'b1, 3, 1'b0);
        send(1'b0, 0, 1'b0);
        send(1'b1, -1, 1'b0);
        send(1'b0, 0, 1'b1);
        check("rs.total_coeff", 32'(tc16), 1);
        check("rs.t1_sign", 32'(sg16), 3'b001);
        check("rs.total_zeros", 32'(tz16), 1);
        idle(2);

        // Asynchronous reset after seven coefficients.
        clear_obs();
        send(1'b1, 1, 1'b0);
        for (int i = 0; i < 6; i++) send(1'b0, (i % 2 == 0) ? 0 : -1, 1'b0);
        rst = 1'b0;
        #1;
        check("rst.total_coeff", 32'(tc16), 0);
        check("rst.run", 32'(run16), 0);
        idle(1);
        rst = 1'b1;
        send(1'b0, 1, 1'b1);
        idle(2);
        check("rst.ignored_total_coeff", 32'(tc16), 0);
        check("rst.sv_pulses", sv_cycles.size(), 0);

        // Synchronous encoder clear after seven coefficients, with a coefficient pending.
        clear_obs();
        send(1'b1, 1, 1'b0);
        for (int i = 0; i < 6; i++) send(1'b0, (i % 2 == 0) ? 0 : 1, 1'b0);
        h264_reset  = 1'b1;
        coeff_valid = 1'b1;
        coeff_i     = 8'd1;
        coeff_last  = 1'b1;
        idle(1);
        h264_reset  = 1'b0;
        coeff_valid = 1'b0;
        coeff_last  = 1'b0;
        coeff_i     = '0;
        check("hr.total_coeff", 32'(tc16), 0);
        check("hr.run", 32'(run16), 0);
        send(1'b0, 1, 1'b1);
        idle(2);
        check("hr.ignored_total_coeff", 32'(tc16), 0);
        check("hr.sv_pulses", sv_cycles.size(), 0);

        // Three trailing ones capped, four runs of zero.
        clear_obs();
        q = '{1, 1, -1, 1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_block(q);
        check("b3.total_coeff", 32'(tc16), 5);
        check("b3.trailing_ones", 32'(to16), 3);
        check("b3.t1_sign", 32'(sg16), 3'b100);
        check("b3.total_zeros", 32'(tz16), 11);
        idle(2);
        check("b3.run_count", runs16.size(), 4);
        for (int i = 0; i < runs16.size() && i < 4; i++) check("b3.run", runs16[i], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
